// File: rtl/bb_uart_defs.sv
// Shared UART definitions for the breakout board: baud divider and receiver state encodings.
// TX and RX take their divider from here so both sides stay on the same bit period.
package bb_uart_defs;

    localparam int unsigned UART_OSC_HZ = 5_000_000;
    localparam int unsigned UART_BAUD   = 9600;

    // Nearest whole number of clocks per bit.
    function automatic int unsigned clk_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    localparam int unsigned UART_CLK_PER_BIT = clk_per_bit(UART_OSC_HZ, UART_BAUD);
    localparam int unsigned UART_HALF_BIT    = UART_CLK_PER_BIT / 2;
    localparam int unsigned UART_CNT_W       = 10;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/bb_uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd line, both flops resetting to idle-high.
// With BB_UART_RX_MAJORITY_EN defined, smp is a 2-of-3 vote over the last three rxd_s values.
module bb_uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s,
    output logic smp
);

    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[0], rxd};
        end
    end

    assign rxd_s = sync[1];

`ifdef BB_UART_RX_MAJORITY_EN
    logic [1:0] hist_q;
    logic [2:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '1;
        end else begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    // Oldest to newest: rxd_s two cycles ago, one cycle ago, now.
    assign hist = {hist_q, rxd_s};
    assign smp  = (hist[2] & hist[1]) | (hist[2] & hist[0]) | (hist[1] & hist[0]);
`else
    assign smp = rxd_s;
`endif

endmodule

// File: rtl/bb_uart_rx.sv
// 8N1 UART receiver sampling rxd at mid-bit; pulses valid with data, or frame_err on a low stop bit.
// Optional build macro BB_UART_RX_MAJORITY_EN enables 3-sample majority voting at each sample point.
module bb_uart_rx
    import bb_uart_defs::*;
#(
    parameter int unsigned CLK_PER_BIT = UART_CLK_PER_BIT,
    parameter int unsigned HALF_BIT    = CLK_PER_BIT / 2,
    parameter int unsigned CNT_W       = UART_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rxd_s;
    logic             smp;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    bb_uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rxd_s (rxd_s),
        .smp   (smp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rxd_s) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == LAST_HALF) begin
                        cnt <= '0;
                        if (smp) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt == LAST_BIT) begin
                        cnt   <= '0;
                        shreg <= {smp, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state   <= RX_STOP;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    // Leaves STOP half a bit early so an immediately following start edge is caught.
                    if (cnt == LAST_BIT) begin
                        cnt <= '0;
                        if (smp) begin
                            data  <= shreg;
                            valid <= 1'b1;
                            state <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rxd_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bb_uart_rx.sv
// Directed testbench for bb_uart_rx at the default 521 clocks per bit.
`timescale 1ns/1ps
module tb_bb_uart_rx;

    localparam int BIT = 521;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_both = 0;
    int last_valid_cyc = 0;
    logic [7:0] last_data = 8'h00;
    int fall_cyc = 0;

    bb_uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            n_valid = n_valid + 1;
            last_valid_cyc = cyc;
            last_data = data;
        end
        if (frame_err === 1'b1) n_ferr = n_ferr + 1;
        if (valid === 1'b1 && frame_err === 1'b1) n_both = n_both + 1;
    end

    initial begin
        #30_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Caller is always 1 time unit after a posedge.
    task automatic hold(input logic b, input int n);
        rxd = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        fall_cyc = cyc;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
        hold(stop_bit, BIT);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        rst = 1'b0;
        hold(1'b1, 10000);
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL idle_valid: got %0d pulses expected 0", n_valid); end
        checks++; if (n_ferr !== 0) begin errors++; $display("FAIL idle_ferr: got %0d pulses expected 0", n_ferr); end
    endtask

    task automatic test_single_byte();
        int v0, f0, lat;
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'h55, 1'b1);
        lat = last_valid_cyc - fall_cyc;
        checks++; if (n_valid !== v0 + 1) begin errors++; $display("FAIL single_count: got %0d expected %0d", n_valid - v0, 1); end
        checks++; if (lat < 4951 || lat > 4953) begin errors++; $display("FAIL single_latency: got %0d expected 4952", lat); end
        checks++; if (last_data !== 8'h55) begin errors++; $display("FAIL single_data: got %h expected 55", last_data); end
        checks++; if (data !== 8'h55) begin errors++; $display("FAIL single_hold: got %h expected 55", data); end
        checks++; if (n_ferr !== f0) begin errors++; $display("FAIL single_ferr: got %0d expected %0d", n_ferr, f0); end
    endtask

    task automatic test_back_to_back();
        int v0, c1, gap;
        logic [7:0] d1;
        v0 = n_valid;
        send_frame(8'hA3, 1'b1);
        c1 = last_valid_cyc;
        d1 = last_data;
        send_frame(8'h00, 1'b1);
        gap = last_valid_cyc - c1;
        checks++; if (n_valid !== v0 + 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", n_valid - v0); end
        checks++; if (d1 !== 8'hA3) begin errors++; $display("FAIL b2b_first: got %h expected a3", d1); end
        checks++; if (last_data !== 8'h00) begin errors++; $display("FAIL b2b_second: got %h expected 00", last_data); end
        checks++; if (gap < 5209 || gap > 5211) begin errors++; $display("FAIL b2b_gap: got %0d expected 5210", gap); end
    endtask

    task automatic test_glitch_frame_err();
        int v0, f0;
        v0 = n_valid;
        f0 = n_ferr;
        hold(1'b0, 100);
        hold(1'b1, 2000);
        checks++; if (n_valid !== v0 || n_ferr !== f0) begin errors++; $display("FAIL glitch_pulse: got valid %0d ferr %0d expected 0 0", n_valid - v0, n_ferr - f0); end
        send_frame(8'h3C, 1'b1);
        checks++; if (n_valid !== v0 + 1) begin errors++; $display("FAIL glitch_recover_count: got %0d expected 1", n_valid - v0); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL glitch_recover_data: got %h expected 3c", data); end
        send_frame(8'hFF, 1'b0);
        hold(1'b0, 3000);
        checks++; if (n_ferr !== f0 + 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", n_ferr - f0); end
        checks++; if (n_valid !== v0 + 1) begin errors++; $display("FAIL ferr_no_valid: got %0d expected 1", n_valid - v0); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL ferr_data_kept: got %h expected 3c", data); end
        hold(1'b1, 12000);
        checks++; if (n_valid !== v0 + 1 || n_ferr !== f0 + 1) begin errors++; $display("FAIL break_no_restart: got valid %0d ferr %0d expected 1 1", n_valid - v0, n_ferr - f0); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, f0;
        logic [7:0] b;
        b = 8'h5A;
        v0 = n_valid;
        f0 = n_ferr;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(b[i], BIT);
        hold(b[4], 200);
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", data); end
        checks++; if (valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL midrst_flags: got %b%b expected 00", valid, frame_err); end
        hold(1'b1, 6000);
        checks++; if (n_valid !== v0 || n_ferr !== f0) begin errors++; $display("FAIL midrst_discard: got valid %0d ferr %0d expected 0 0", n_valid - v0, n_ferr - f0); end
        send_frame(8'h81, 1'b1);
        checks++; if (n_valid !== v0 + 1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", n_valid - v0); end
        checks++; if (data !== 8'h81) begin errors++; $display("FAIL midrst_next_data: got %h expected 81", data); end
    endtask

    task automatic test_majority_spike();
        int v0, f0;
        logic [7:0] exp_data;
`ifdef BB_UART_RX_MAJORITY_EN
        exp_data = 8'hFF;
`else
        exp_data = 8'h00;
`endif
        v0 = n_valid;
        f0 = n_ferr;
        hold(1'b0, BIT);
        // Spike timed so rxd_s is low only in the cycle each data bit is sampled.
        for (int i = 0; i < 8; i++) begin
            hold(1'b1, 260);
            hold(1'b0, 1);
            hold(1'b1, 260);
        end
        hold(1'b1, BIT);
        checks++; if (n_valid !== v0 + 1) begin errors++; $display("FAIL spike_count: got %0d expected 1", n_valid - v0); end
        checks++; if (data !== exp_data) begin errors++; $display("FAIL spike_data: got %h expected %h", data, exp_data); end
        checks++; if (n_ferr !== f0) begin errors++; $display("FAIL spike_ferr: got %0d expected %0d", n_ferr, f0); end
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch_frame_err();
        test_reset_mid_frame();
        test_majority_spike();
        checks++; if (n_both !== 0) begin errors++; $display("FAIL exclusive_flags: got %0d overlaps expected 0", n_both); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
